// File: rtl/fifo_word_serializer_pkg.sv
// Shared definitions for the FIFO word serializer and its future deserializer twin.
// State encoding plus width-ratio helpers.
package fifo_word_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  function automatic int ratio_of(input int data_w, input int beat_w);
    return data_w / beat_w;
  endfunction

  function automatic int cnt_w_of(input int data_w, input int beat_w);
    return (data_w / beat_w) > 1 ? $clog2(data_w / beat_w) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a FWFT FIFO and streams them out as narrow valid/ready beats.
// Zero-bubble reload on the last beat when the FIFO still has data.
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_n_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int RATIO = ratio_of(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_W = cnt_w_of(DATA_WIDTH, OUT_WIDTH);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_cfg
    $error("fifo_word_serializer: bad DATA_WIDTH/OUT_WIDTH");
  end

  ser_state_e            state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  pop;
  logic                  last;
  logic [OUT_WIDTH-1:0]  head_beat;

  assign last = (state_q == ST_SHIFT) &&
                (beat_cnt_q == CNT_W'(RATIO - 1));

  if (MSB_FIRST) begin : g_msb
    assign head_beat = shift_q[DATA_WIDTH-1 -: OUT_WIDTH];
  end else begin : g_lsb
    assign head_beat = shift_q[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    if (flush) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fifo_n_empty) begin
            pop        = 1'b1;
            shift_d    = fifo_data;
            beat_cnt_d = '0;
            state_d    = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (!last) begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
              shift_d    = MSB_FIRST ? (shift_q << OUT_WIDTH)
                                     : (shift_q >> OUT_WIDTH);
            end else if (fifo_n_empty) begin
              pop        = 1'b1;
              shift_d    = fifo_data;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = '0;
              state_d    = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Pop strobe must die with reset, not wait for a clock.
  assign fifo_r_en = pop & reset_n;
  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = busy;
  assign out_last  = last;
  assign out_data  = busy ? head_beat : '0;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Randomized plus directed bench for fifo_word_serializer (LSB- and MSB-first).
// A transaction-level beat model decides every expected output.
module tb_fifo_word_serializer;

  localparam int DW = 16;
  localparam int OW = 4;
  localparam int R  = DW / OW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_n_empty = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          r_en_l, val_l, last_l, busy_l;
  logic [OW-1:0] data_l;
  logic          r_en_m, val_m, last_m, busy_m;
  logic [OW-1:0] data_m;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  bit            m_busy;
  logic [DW-1:0] m_word;
  int            m_k;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0))
  u_lsb (
    .clk(clk), .reset_n(reset_n),
    .fifo_n_empty(fifo_n_empty), .fifo_data(fifo_data),
    .fifo_r_en(r_en_l), .flush(flush),
    .out_valid(val_l), .out_data(data_l), .out_last(last_l),
    .out_ready(out_ready), .busy(busy_l)
  );

  fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1))
  u_msb (
    .clk(clk), .reset_n(reset_n),
    .fifo_n_empty(fifo_n_empty), .fifo_data(fifo_data),
    .fifo_r_en(r_en_m), .flush(flush),
    .out_valid(val_m), .out_data(data_m), .out_last(last_m),
    .out_ready(out_ready), .busy(busy_m)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] beat(input logic [DW-1:0] w,
                                         input int k, input bit msb);
    logic [DW-1:0] s;
    s = msb ? (w >> (DW - OW * (k + 1))) : (w >> (OW * k));
    return s[OW-1:0];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_k    = 0;
    m_word = '0;
    fq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_val_l"},  16'(val_l),  16'h0);
    chk({tag, "_busy_l"}, 16'(busy_l), 16'h0);
    chk({tag, "_ren_l"},  16'(r_en_l), 16'h0);
    chk({tag, "_dat_l"},  16'(data_l), 16'h0);
    chk({tag, "_lst_l"},  16'(last_l), 16'h0);
    chk({tag, "_val_m"},  16'(val_m),  16'h0);
    chk({tag, "_busy_m"}, 16'(busy_m), 16'h0);
    chk({tag, "_ren_m"},  16'(r_en_m), 16'h0);
  endtask

  task automatic step(input bit rdy, input bit fl);
    bit            e_last, e_pop;
    logic [DW-1:0] head;
    @(negedge clk);
    out_ready    = rdy;
    flush        = fl;
    fifo_n_empty = (fq.size() != 0);
    head         = fifo_n_empty ? fq[0] : '0;
    fifo_data    = head;
    #1;
    e_last = m_busy && (m_k == R - 1);
    e_pop  = !fl && fifo_n_empty && (!m_busy || (rdy && e_last));
    chk("valid_l", 16'(val_l),  16'(m_busy));
    chk("busy_l",  16'(busy_l), 16'(m_busy));
    chk("last_l",  16'(last_l), 16'(e_last));
    chk("ren_l",   16'(r_en_l), 16'(e_pop));
    chk("data_l",  16'(data_l), m_busy ? 16'(beat(m_word, m_k, 1'b0)) : 16'h0);
    chk("valid_m", 16'(val_m),  16'(m_busy));
    chk("last_m",  16'(last_m), 16'(e_last));
    chk("ren_m",   16'(r_en_m), 16'(e_pop));
    chk("data_m",  16'(data_m), m_busy ? 16'(beat(m_word, m_k, 1'b1)) : 16'h0);
    @(posedge clk);
    if (fl) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else if (e_pop) begin
      void'(fq.pop_front());
      m_busy = 1'b1;
      m_word = head;
      m_k    = 0;
    end else if (m_busy && rdy) begin
      if (e_last) begin
        m_busy = 1'b0;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk_reset_outs("rst");
    fq.push_back(16'hA5C3);
    #1;
    fifo_n_empty = 1'b1;
    fifo_data    = 16'hA5C3;
    #1;
    chk("rst_ren_gated", 16'(r_en_l), 16'h0);
    fifo_n_empty = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Single word, both beat orders.
    fq.push_back(16'hA5C3);
    repeat (6) step(1'b1, 1'b0);

    // Back-to-back words with no bubble.
    fq.push_back(16'h1234);
    fq.push_back(16'hBEEF);
    repeat (10) step(1'b1, 1'b0);

    // Backpressure in the middle of a word.
    fq.push_back(16'hA5C3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);

    // Flush after beat 1, then a fresh word.
    fq.push_back(16'hA5C3);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    fq.push_back(16'h0F0F);
    repeat (6) step(1'b1, 1'b0);

    // Reset mid-word, applied away from a clock edge.
    fq.push_back(16'hA5C3);
    repeat (3) step(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (fq.size() < 4 && ($urandom % 3) == 0)
        fq.push_back(DW'($urandom));
      step(($urandom % 4) != 0, ($urandom % 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
